// File: rtl/game_master_fsm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_master_fsm_multi_pkg
// Description : Shared state encoding and limits for the multi-target game
//               master.
// Revision    : 1.0 - initial release
// ============================================================================
package game_master_fsm_multi_pkg;

  // Legal range for the number of target sprites.
  localparam int MIN_TARGETS = 1;
  localparam int MAX_TARGETS = 8;

  // Game master states, 3-bit explicit encoding.
  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_AIM    = 3'd1,
    ST_SHOOT  = 3'd2,
    ST_RELOAD = 3'd3,
    ST_END    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/game_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : game_score_counter
// Description : Adds the number of set bits of inc_vec to a saturating
//               SCORE_W-bit score every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module game_score_counter #(
  parameter int N_IN    = 2,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_IN-1:0]    inc_vec,
  output logic [SCORE_W-1:0] score
);

  // Four guard bits cover the largest possible increment (8 hits).
  localparam int SUM_W = SCORE_W + 4;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((1 << SCORE_W) - 1);

  logic [SUM_W-1:0]   inc_count;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] score_q;

  // Popcount of the increment vector, then clamp the sum at the maximum score.
  always_comb begin
    inc_count = '0;
    for (int i = 0; i < N_IN; i++) begin
      inc_count = inc_count + SUM_W'(inc_vec[i]);
    end
    sum = SUM_W'(score_q) + inc_count;
    if (sum > SCORE_MAX) begin
      score_d = SCORE_MAX[SCORE_W-1:0];
    end else begin
      score_d = sum[SCORE_W-1:0];
    end
  end

  // Score register; only a reset clears it, so it persists across rounds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule
`default_nettype wire

// File: rtl/game_master_fsm_multi.sv
`default_nettype none
// ============================================================================
// Module      : game_master_fsm_multi
// Description : Game master sequencing one torpedo against N_TARGETS targets
//               with a per-round shot budget, kill tracking and a saturating
//               score. Every output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module game_master_fsm_multi
  import game_master_fsm_multi_pkg::*;
#(
  parameter  int N_TARGETS = 2,
  parameter  int N_SHOTS   = 3,
  parameter  int SCORE_W   = 8,
  localparam int SHOTS_W   = $clog2(N_SHOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 key,
  output logic [N_TARGETS-1:0] sprite_target_write_xy,
  output logic [N_TARGETS-1:0] sprite_target_write_dxy,
  output logic [N_TARGETS-1:0] sprite_target_enable_update,
  output logic                 sprite_torpedo_write_xy,
  output logic                 sprite_torpedo_write_dxy,
  output logic                 sprite_torpedo_enable_update,
  input  logic [N_TARGETS-1:0] sprite_target_within_screen,
  input  logic                 sprite_torpedo_within_screen,
  input  logic [N_TARGETS-1:0] collision,
  output logic                 end_of_game_timer_start,
  input  logic                 end_of_game_timer_running,
  output logic                 game_won,
  output logic [SCORE_W-1:0]   score,
  output logic [SHOTS_W-1:0]   shots_left
);

  generate
    if (N_TARGETS < MIN_TARGETS || N_TARGETS > MAX_TARGETS) begin : g_bad_n_targets
      $error("game_master_fsm_multi: N_TARGETS must be within 1..8");
    end
    if (N_SHOTS < 1) begin : g_bad_n_shots
      $error("game_master_fsm_multi: N_SHOTS must be at least 1");
    end
  endgenerate

  state_e               state_d, state_q;
  logic [N_TARGETS-1:0] alive_d, alive_q;
  logic [SHOTS_W-1:0]   shots_d, shots_q;
  logic                 won_d, won_q;
  logic                 fired_d, fired_q;   // high during the first SHOOT cycle
  logic [N_TARGETS-1:0] hit;
  logic                 lost;

  logic [N_TARGETS-1:0] tgt_write_xy_d, tgt_write_xy_q;
  logic [N_TARGETS-1:0] tgt_write_dxy_d, tgt_write_dxy_q;
  logic [N_TARGETS-1:0] tgt_enable_d, tgt_enable_q;
  logic                 torp_write_xy_d, torp_write_xy_q;
  logic                 torp_write_dxy_d, torp_write_dxy_q;
  logic                 torp_enable_d, torp_enable_q;
  logic                 timer_start_d, timer_start_q;

  // Next-state, round bookkeeping and next-output decode.
  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    shots_d = shots_q;
    won_d   = won_q;
    fired_d = 1'b0;
    hit     = '0;
    lost    = |(alive_q & ~sprite_target_within_screen);

    case (state_q)
      ST_START: begin
        alive_d = '1;
        shots_d = SHOTS_W'(N_SHOTS);
        won_d   = 1'b0;
        state_d = ST_AIM;
      end
      ST_AIM: begin
        if (lost) begin
          state_d = ST_END;
        end else if (key) begin
          state_d = ST_SHOOT;
          shots_d = shots_q - SHOTS_W'(1);
          fired_d = 1'b1;
        end
      end
      ST_SHOOT: begin
        // Only live targets can be hit; a kill also stops it counting as lost.
        hit     = collision & alive_q;
        alive_d = alive_q & ~hit;
        lost    = |(alive_d & ~sprite_target_within_screen);
        if (alive_d == '0) begin
          state_d = ST_END;
          won_d   = 1'b1;
        end else if (lost) begin
          state_d = ST_END;
        end else if ((|hit) || !sprite_torpedo_within_screen) begin
          state_d = (shots_q != '0) ? ST_RELOAD : ST_END;
        end
      end
      ST_RELOAD: begin
        state_d = ST_AIM;
      end
      ST_END: begin
        if (!end_of_game_timer_running) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    tgt_write_xy_d   = {N_TARGETS{state_q == ST_START}};
    tgt_write_dxy_d  = {N_TARGETS{state_q == ST_START}};
    tgt_enable_d     = (state_q == ST_AIM || state_q == ST_SHOOT || state_q == ST_RELOAD)
                       ? alive_q : '0;
    torp_write_xy_d  = (state_q == ST_START) || (state_q == ST_RELOAD);
    torp_write_dxy_d = (state_q == ST_SHOOT) && fired_q;
    torp_enable_d    = (state_q == ST_SHOOT);
    timer_start_d    = (state_d == ST_END) && (state_q != ST_END);
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_START;
      alive_q          <= '0;
      shots_q          <= '0;
      won_q            <= 1'b0;
      fired_q          <= 1'b0;
      tgt_write_xy_q   <= '0;
      tgt_write_dxy_q  <= '0;
      tgt_enable_q     <= '0;
      torp_write_xy_q  <= 1'b0;
      torp_write_dxy_q <= 1'b0;
      torp_enable_q    <= 1'b0;
      timer_start_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      alive_q          <= alive_d;
      shots_q          <= shots_d;
      won_q            <= won_d;
      fired_q          <= fired_d;
      tgt_write_xy_q   <= tgt_write_xy_d;
      tgt_write_dxy_q  <= tgt_write_dxy_d;
      tgt_enable_q     <= tgt_enable_d;
      torp_write_xy_q  <= torp_write_xy_d;
      torp_write_dxy_q <= torp_write_dxy_d;
      torp_enable_q    <= torp_enable_d;
      timer_start_q    <= timer_start_d;
    end
  end

  game_score_counter #(
    .N_IN    (N_TARGETS),
    .SCORE_W (SCORE_W)
  ) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_vec (hit),
    .score   (score)
  );

  assign sprite_target_write_xy       = tgt_write_xy_q;
  assign sprite_target_write_dxy      = tgt_write_dxy_q;
  assign sprite_target_enable_update  = tgt_enable_q;
  assign sprite_torpedo_write_xy      = torp_write_xy_q;
  assign sprite_torpedo_write_dxy     = torp_write_dxy_q;
  assign sprite_torpedo_enable_update = torp_enable_q;
  assign end_of_game_timer_start      = timer_start_q;
  assign game_won                     = won_q;
  assign shots_left                   = shots_q;

endmodule
`default_nettype wire
